algo_mrpnwp_1r1w_rsp: RTL and testbench

//  Physical-side responder for the mrpnwp 1r1w core.
//  - Consumes the core's pwrite/pdin/pread request buses.
//  - Holds NUMADDR x WIDTH of storage and returns read data on t1_doutB with vread_vld_bus/vread_padr_bus.
//  - Read results arrive after a fixed SRAM_DELAY.
//  - Clears its storage after reset and gates requests until ready.

---
 rtl/mrpnwp_pkg.sv | 23 ++
 rtl/algo_mrpnwp_rdpipe.sv | 54 +++++
 rtl/algo_mrpnwp_1r1w_rsp.sv | 113 +++++++++++
 tb/tb_algo_mrpnwp_1r1w_rsp.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mrpnwp_pkg.sv
// rtl/mrpnwp_pkg.sv - shared state encoding and address helpers for the mrpnwp responder
package mrpnwp_pkg;

   // Init/run FSM encoding
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Addresses are widened to a common type before comparison
   localparam int ADR_W = 32;
   typedef logic [ADR_W-1:0] adr_t;

   // True when an address falls outside the populated storage rows
   function automatic logic adr_oor(input adr_t adr, input adr_t numaddr);
      return adr >= numaddr;
   endfunction

   // True when two enabled write ports target the same row; the lower port then yields
   function automatic logic wr_hit(input logic en_a, input adr_t adr_a,
                                   input logic en_b, input adr_t adr_b);
      return en_a && en_b && (adr_a == adr_b);
   endfunction

endpackage

// File: rtl/algo_mrpnwp_rdpipe.sv
// rtl/algo_mrpnwp_rdpipe.sv - fixed-latency read pipe carrying vld, padr and data per read port
module algo_mrpnwp_rdpipe #(
   parameter int NUMRDPT = 2,
   parameter int WIDTH   = 32,
   parameter int BITPADR = 13,
   parameter int DELAY   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUMRDPT-1:0]         req_vld,
   input  logic [NUMRDPT*BITPADR-1:0] req_padr,
   input  logic [NUMRDPT*WIDTH-1:0]   req_data,
   output logic [NUMRDPT-1:0]         rsp_vld,
   output logic [NUMRDPT*BITPADR-1:0] rsp_padr,
   output logic [NUMRDPT*WIDTH-1:0]   rsp_data
);

   logic [NUMRDPT-1:0]         vld_q  [DELAY];
   logic [NUMRDPT*BITPADR-1:0] padr_q [DELAY];
   logic [NUMRDPT*WIDTH-1:0]   data_q [DELAY];

   // Shift every stage each cycle; padr/data only move with a valid so the output holds between reads
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < DELAY; s++) begin
            vld_q[s]  <= '0;
            padr_q[s] <= '0;
            data_q[s] <= '0;
         end
      end else begin
         vld_q[0] <= req_vld;
         for (int i = 0; i < NUMRDPT; i++) begin
            if (req_vld[i]) begin
               padr_q[0][i*BITPADR +: BITPADR] <= req_padr[i*BITPADR +: BITPADR];
               data_q[0][i*WIDTH +: WIDTH]     <= req_data[i*WIDTH +: WIDTH];
            end
         end
         for (int s = 1; s < DELAY; s++) begin
            vld_q[s] <= vld_q[s-1];
            for (int i = 0; i < NUMRDPT; i++) begin
               if (vld_q[s-1][i]) begin
                  padr_q[s][i*BITPADR +: BITPADR] <= padr_q[s-1][i*BITPADR +: BITPADR];
                  data_q[s][i*WIDTH +: WIDTH]     <= data_q[s-1][i*WIDTH +: WIDTH];
               end
            end
         end
      end
   end

   assign rsp_vld  = vld_q[DELAY-1];
   assign rsp_padr = padr_q[DELAY-1];
   assign rsp_data = data_q[DELAY-1];

endmodule

// File: rtl/algo_mrpnwp_1r1w_rsp.sv
// rtl/algo_mrpnwp_1r1w_rsp.sv - physical-side storage responder for the mrpnwp 1r1w core
module algo_mrpnwp_1r1w_rsp
   import mrpnwp_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int NUMRDPT    = 2,
   parameter int NUMWRPT    = 3,
   parameter int NUMADDR    = 8192,
   parameter int BITPADR    = 13,
   parameter int SRAM_DELAY = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       ready,
   input  logic [NUMWRPT-1:0]         pwrite,
   input  logic [NUMWRPT*BITPADR-1:0] pwradr,
   input  logic [NUMWRPT*WIDTH-1:0]   pdin,
   input  logic [NUMRDPT-1:0]         pread,
   input  logic [NUMRDPT*BITPADR-1:0] pradr,
   output logic [NUMRDPT*WIDTH-1:0]   t1_doutB,
   output logic [NUMRDPT-1:0]         vread_vld_bus,
   output logic [NUMRDPT*BITPADR-1:0] vread_padr_bus,
   output logic                       wr_coll
);

   localparam int AW = (NUMADDR > 1) ? $clog2(NUMADDR) : 1;

   logic [WIDTH-1:0]         mem [NUMADDR];
   logic [0:0]               state;
   logic [AW-1:0]            init_cnt;
   adr_t                     wa [NUMWRPT];
   adr_t                     ra [NUMRDPT];
   logic [NUMWRPT-1:0]       wr_en;
   logic                     coll_d;
   logic [NUMRDPT-1:0]       rd_vld;
   logic [NUMRDPT*WIDTH-1:0] rd_data;

   assign ready = (state == ST_RUN);

   // Widen per-port addresses to the common compare type
   always_comb begin
      for (int j = 0; j < NUMWRPT; j++) wa[j] = adr_t'(pwradr[j*BITPADR +: BITPADR]);
      for (int i = 0; i < NUMRDPT; i++) ra[i] = adr_t'(pradr[i*BITPADR +: BITPADR]);
   end

   // Write merge: drop out-of-range writes, mask a port whenever a higher port hits the same row
   always_comb begin
      wr_en  = '0;
      coll_d = 1'b0;
      for (int j = 0; j < NUMWRPT; j++) begin
         wr_en[j] = ready && pwrite[j] && !adr_oor(wa[j], adr_t'(NUMADDR));
         for (int k = j + 1; k < NUMWRPT; k++) begin
            if (wr_hit(ready && pwrite[j], wa[j], ready && pwrite[k], wa[k])) begin
               wr_en[j] = 1'b0;
               coll_d   = 1'b1;
            end
         end
      end
   end

   // Storage: clear one row per cycle during init, then apply the merged writes
   always_ff @(posedge clk) begin
      if (state == ST_INIT) begin
         mem[init_cnt] <= '0;
      end else begin
         for (int j = 0; j < NUMWRPT; j++) begin
            if (wr_en[j]) mem[wa[j][AW-1:0]] <= pdin[j*WIDTH +: WIDTH];
         end
      end
   end

   // Init FSM and registered collision flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_INIT;
         init_cnt <= '0;
         wr_coll  <= 1'b0;
      end else begin
         wr_coll <= coll_d;
         if (state == ST_INIT) begin
            if (init_cnt == AW'(NUMADDR - 1)) state <= ST_RUN;
            else init_cnt <= init_cnt + 1'b1;
         end
      end
   end

   // Read sample: storage contents before this cycle's writes; out-of-range rows read as zero
   always_comb begin
      rd_vld  = '0;
      rd_data = '0;
      for (int i = 0; i < NUMRDPT; i++) begin
         rd_vld[i] = ready && pread[i];
         if (!adr_oor(ra[i], adr_t'(NUMADDR))) rd_data[i*WIDTH +: WIDTH] = mem[ra[i][AW-1:0]];
      end
   end

   algo_mrpnwp_rdpipe #(
      .NUMRDPT (NUMRDPT),
      .WIDTH   (WIDTH),
      .BITPADR (BITPADR),
      .DELAY   (SRAM_DELAY)
   ) u_rdpipe (
      .clk      (clk),
      .rst      (rst),
      .req_vld  (rd_vld),
      .req_padr (pradr),
      .req_data (rd_data),
      .rsp_vld  (vread_vld_bus),
      .rsp_padr (vread_padr_bus),
      .rsp_data (t1_doutB)
   );

endmodule

// File: tb/tb_algo_mrpnwp_1r1w_rsp.sv
// tb/tb_algo_mrpnwp_1r1w_rsp.sv - directed self-checking bench for algo_mrpnwp_1r1w_rsp
module tb_algo_mrpnwp_1r1w_rsp;

   localparam int WIDTH      = 32;
   localparam int NUMRDPT    = 2;
   localparam int NUMWRPT    = 3;
   localparam int NUMADDR    = 8192;
   localparam int BITPADR    = 14;
   localparam int SRAM_DELAY = 2;

   logic                       clk = 1'b0;
   logic                       rst = 1'b0;
   logic                       ready;
   logic [NUMWRPT-1:0]         pwrite = '0;
   logic [NUMWRPT*BITPADR-1:0] pwradr = '0;
   logic [NUMWRPT*WIDTH-1:0]   pdin = '0;
   logic [NUMRDPT-1:0]         pread = '0;
   logic [NUMRDPT*BITPADR-1:0] pradr = '0;
   logic [NUMRDPT*WIDTH-1:0]   t1_doutB;
   logic [NUMRDPT-1:0]         vread_vld_bus;
   logic [NUMRDPT*BITPADR-1:0] vread_padr_bus;
   logic                       wr_coll;

   int checks = 0;
   int errors = 0;

   algo_mrpnwp_1r1w_rsp #(
      .WIDTH(WIDTH), .NUMRDPT(NUMRDPT), .NUMWRPT(NUMWRPT),
      .NUMADDR(NUMADDR), .BITPADR(BITPADR), .SRAM_DELAY(SRAM_DELAY)
   ) dut (
      .clk(clk), .rst(rst), .ready(ready),
      .pwrite(pwrite), .pwradr(pwradr), .pdin(pdin),
      .pread(pread), .pradr(pradr),
      .t1_doutB(t1_doutB), .vread_vld_bus(vread_vld_bus),
      .vread_padr_bus(vread_padr_bus), .wr_coll(wr_coll)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pwrite = '0;
      pread  = '0;
   endtask

   task automatic wr(input int j, input logic [BITPADR-1:0] adr, input logic [31:0] d);
      pwrite[j] = 1'b1;
      pwradr[j*BITPADR +: BITPADR] = adr;
      pdin[j*WIDTH +: WIDTH] = d;
   endtask

   task automatic rd_set(input int p, input logic [BITPADR-1:0] adr);
      pread[p] = 1'b1;
      pradr[p*BITPADR +: BITPADR] = adr;
   endtask

   task automatic dout_chk(input string tag, input int p, input logic [BITPADR-1:0] adr,
                           input logic [31:0] exp);
      chk({tag, "_data"}, t1_doutB[p*WIDTH +: WIDTH], exp);
      chk({tag, "_padr"}, 32'(vread_padr_bus[p*BITPADR +: BITPADR]), 32'(adr));
   endtask

   task automatic read_chk(input string tag, input int p, input logic [BITPADR-1:0] adr,
                           input logic [31:0] exp);
      rd_set(p, adr);
      cyc();
      idle();
      chk({tag, "_early"}, 32'(vread_vld_bus), 32'd0);
      cyc();
      chk({tag, "_vld"}, 32'(vread_vld_bus), 32'(1 << p));
      dout_chk(tag, p, adr, exp);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 20000) begin
         cyc();
         n++;
      end
   endtask

   function automatic logic [31:0] pat(input int k);
      return 32'h5A00_0000 + 32'(k) * 32'h0000_0101;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // Reset state
      idle();
      repeat (3) cyc();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_vld", 32'(vread_vld_bus), 32'd0);
      chk("rst_dout", t1_doutB[31:0], 32'd0);
      chk("rst_padr", 32'(vread_padr_bus[BITPADR-1:0]), 32'd0);
      chk("rst_coll", 32'(wr_coll), 32'd0);

      // Init length and top-row read
      rst = 1'b1;
      rd_set(0, 14'h0005);
      wait_ready(n);
      chk("init_cycles", 32'(n), 32'd8192);
      idle();
      chk("init_gate_vld", 32'(vread_vld_bus), 32'd0);
      read_chk("top_row", 0, 14'h1FFF, 32'h0);

      // Write then read next cycle on the other port
      wr(0, 14'h010, 32'hDEADBEEF);
      cyc();
      idle();
      read_chk("wr_rd", 1, 14'h010, 32'hDEADBEEF);

      // Triple same-address write: highest port wins, collision pulses once
      wr(0, 14'h020, 32'h11);
      wr(1, 14'h020, 32'h22);
      wr(2, 14'h020, 32'h33);
      chk("coll_before", 32'(wr_coll), 32'd0);
      cyc();
      idle();
      chk("coll_pulse", 32'(wr_coll), 32'd1);
      cyc();
      chk("coll_clear", 32'(wr_coll), 32'd0);
      read_chk("coll_win", 0, 14'h020, 32'h33);

      // Distinct addresses on two ports: no collision
      wr(0, 14'h040, 32'h1);
      wr(1, 14'h041, 32'h2);
      cyc();
      idle();
      chk("nocoll", 32'(wr_coll), 32'd0);
      read_chk("nocoll_p0", 0, 14'h040, 32'h1);
      read_chk("nocoll_p1", 1, 14'h041, 32'h2);

      // Read-before-write on the same row
      wr(0, 14'h030, 32'h5);
      rd_set(1, 14'h030);
      cyc();
      idle();
      cyc();
      chk("rbw_vld", 32'(vread_vld_bus), 32'd2);
      dout_chk("rbw_old", 1, 14'h030, 32'h0);
      read_chk("rbw_new", 1, 14'h030, 32'h5);

      // Prefill 200 rows for streaming reads
      for (int k = 0; k < 200; k += 3) begin
         for (int j = 0; j < 3; j++) begin
            if (k + j < 200) wr(j, BITPADR'(256 + k + j), pat(k + j));
         end
         cyc();
         idle();
      end

      // 100 back-to-back reads per port, results one per cycle
      for (int c = 0; c <= 100; c++) begin
         if (c < 100) begin
            rd_set(0, BITPADR'(256 + c));
            rd_set(1, BITPADR'(356 + c));
         end else begin
            idle();
         end
         cyc();
         if (c >= 1) begin
            chk("stream_vld", 32'(vread_vld_bus), 32'd3);
            dout_chk("stream_p0", 0, BITPADR'(256 + c - 1), pat(c - 1));
            dout_chk("stream_p1", 1, BITPADR'(356 + c - 1), pat(100 + c - 1));
         end
      end
      cyc();
      chk("stream_end_vld", 32'(vread_vld_bus), 32'd0);
      dout_chk("stream_hold", 0, BITPADR'(355), pat(99));

      // Out-of-range write and read
      wr(0, 14'd8192, 32'h77);
      rd_set(1, 14'd8192);
      cyc();
      idle();
      cyc();
      chk("oor_vld", 32'(vread_vld_bus), 32'd2);
      dout_chk("oor_rd", 1, 14'd8192, 32'h0);
      read_chk("oor_alias", 0, 14'h0000, 32'h0);

      // Reset with reads in flight
      wr(0, 14'h050, 32'hAB);
      cyc();
      idle();
      rd_set(0, 14'h010);
      rd_set(1, 14'h050);
      cyc();
      idle();
      rst = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(ready), 32'd0);
      chk("mid_rst_vld0", 32'(vread_vld_bus), 32'd0);
      cyc();
      chk("mid_rst_vld1", 32'(vread_vld_bus), 32'd0);
      cyc();
      chk("mid_rst_vld2", 32'(vread_vld_bus), 32'd0);
      rst = 1'b1;
      cyc();
      chk("reinit_vld", 32'(vread_vld_bus), 32'd0);
      wait_ready(n);
      chk("reinit_cycles", 32'(n + 1), 32'd8192);
      read_chk("reinit_a", 0, 14'h010, 32'h0);
      read_chk("reinit_b", 1, 14'h050, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
